pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
- Control-path pipeline companion to the ID-stage instruction decoder in the MIPS 5-stage CPU.
- Consumes the decoder's per-instruction control bundle and the ID-stage instruction, and carries the control through ID/EX, EX/MEM and MEM/WB.
- Detects RAW hazards (stall-only, no forwarding) and issues stall/flush to the fetch stage.
- Resolves the writeback register address and keeps hazard/illegal-instruction status.

Parameters:
- LINK_REG, 31, register number written by WB_ADDR_LINK.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  main clock
- rst  in  1  asynchronous reset, active low
- en  in  1  CPU enable from debug control; 0 freezes all state
- id_valid  in  1  ID holds a real instruction (0 = bubble)
- id_inst  in  32  ID-stage instruction (rs=[25:21], rt=[20:16], rd=[15:11])
- id_pc_src  in  3  decoder pc_src
- id_exe_a_src, id_exe_b_src  in  2 each  decoder operand selects
- id_exe_alu_oper  in  4  decoder ALU op
- id_mem_ren, id_mem_wen, id_wb_data_src, id_wb_wen, id_unrecognized  in  1 each  decoder outputs
- id_wb_addr_src  in  2  decoder writeback address select
- ex_branch_taken  in  1  EX branch comparison result for the instruction in EX
- if_stall  out  1  hold PC and IF/ID register
- if_flush  out  1  squash IF/ID contents on the next edge
- exe_valid, exe_alu_oper[3:0], exe_a_src[1:0], exe_b_src[1:0], exe_is_branch  out  registered EX control
- mem_valid, mem_ren, mem_wen  out  registered MEM control
- wb_valid, wb_wen, wb_data_src, wb_addr[4:0]  out  registered WB control
- illegal_seen  out  1  sticky: an unrecognized instruction reached WB
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst=0, asynchronous): all valid/wen/ren/illegal_seen outputs = 0; all other registered outputs = 0; stall_count = 0. Reset mid-operation discards every in-flight instruction.
- Address resolution in ID: WB_ADDR_RD→rd, WB_ADDR_RT→rt, WB_ADDR_LINK→LINK_REG. An unrecognized instruction forces wen/mem_wen/mem_ren = 0 but keeps valid=1 and flows to WB.
- Source use in ID: rs is used if exe_a_src==EXE_A_RS, or pc_src is PC_JR or PC_BRANCH. rt is used if exe_b_src==EXE_B_RT or mem_wen=1.
- Hazard: id_valid, used source ≠ 0, and the source equals the dest address of a valid, wen=1 instruction in EX or MEM. WB is not checked; the register file writes first-half.
- if_stall = hazard & ~ex_branch_taken.
- On stall: the ID/EX slot loads a bubble (valid=0, all enables 0); EX/MEM and MEM/WB advance normally.
- if_flush = ex_branch_taken | (id_valid & ~if_stall & id_pc_src ∈ {PC_JUMP, PC_JR}).
- On ex_branch_taken: the ID/EX slot loads a bubble. Flush has priority over stall.
- Normal advance each enabled edge: ID→EX, EX→MEM, MEM→WB. Latency is 1 cycle per stage; WB outputs appear 3 edges after ID acceptance.
- en=0: no register changes (including stall_count and illegal_seen). if_stall and if_flush are forced to 0.
- illegal_seen sets when a valid unrecognized instruction enters WB. It clears only on reset.
- stall_count increments on each enabled edge with if_stall=1 and saturates at all-ones (no wrap).
- if_stall and if_flush are combinational from the current ID inputs and the EX/MEM registers. All other outputs are registered.

Test Plan:
- Reset with rst=0 mid-stream → all outputs 0 immediately (asynchronous, before the next clk edge).
- ADD r3 in ID, then SUB using rs=r3 next cycle → if_stall=1 for 2 cycles, two bubbles reach WB, SUB wb_addr=3 three cycles after release; stall_count=2.
- Producer writes r0, consumer reads r0 → no stall. LW rt=5 followed by SW rt=5 → stall (rt used via mem_wen).
- BEQ in EX with ex_branch_taken=1 while ID holds a hazarding instruction → if_stall=0, if_flush=1, EX slot bubble.
- JAL in ID → if_flush=1 one cycle; at WB, wb_addr=31, wb_wen=1. J → if_flush=1, no writeback.
- Unrecognized opcode → flows with wen=0; illegal_seen=1 from the cycle it reaches WB, persists. Hold en=0 for 5 cycles mid-stream → all registers unchanged. Force >2^CNT_W stalls → stall_count stays 0xFFFF.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Control-path pipeline for the MIPS 5-stage core.
// Takes the ID-stage decoder bundle, carries it through ID/EX, EX/MEM and MEM/WB.
// Detects RAW hazards against EX and MEM (no forwarding) and drives IF stall/flush.
// Also keeps the sticky illegal-instruction flag and a saturating stall counter.
module pipe_ctrl_unit #(
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic [2:0]       id_pc_src,
  input  logic [1:0]       id_exe_a_src,
  input  logic [1:0]       id_exe_b_src,
  input  logic [3:0]       id_exe_alu_oper,
  input  logic             id_mem_ren,
  input  logic             id_mem_wen,
  input  logic             id_wb_data_src,
  input  logic             id_wb_wen,
  input  logic             id_unrecognized,
  input  logic [1:0]       id_wb_addr_src,
  input  logic             ex_branch_taken,
  output logic             if_stall,
  output logic             if_flush,
  output logic             exe_valid,
  output logic [3:0]       exe_alu_oper,
  output logic [1:0]       exe_a_src,
  output logic [1:0]       exe_b_src,
  output logic             exe_is_branch,
  output logic             mem_valid,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic             wb_valid,
  output logic             wb_wen,
  output logic             wb_data_src,
  output logic [4:0]       wb_addr,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] stall_count
);

  // Decoder encodings shared with the ID-stage decoder.
  localparam logic [2:0] PC_NEXT      = 3'd0;
  localparam logic [2:0] PC_JUMP      = 3'd1;
  localparam logic [2:0] PC_JR        = 3'd2;
  localparam logic [2:0] PC_BRANCH    = 3'd3;
  localparam logic [1:0] EXE_A_RS     = 2'd0;
  localparam logic [1:0] EXE_B_RT     = 2'd0;
  localparam logic [1:0] WB_ADDR_RD   = 2'd0;
  localparam logic [1:0] WB_ADDR_RT   = 2'd1;
  localparam logic [1:0] WB_ADDR_LINK = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Pipeline state that is not directly visible on the ports.
  logic       exe_mem_ren, exe_mem_wen, exe_wb_wen, exe_wb_data_src, exe_unrec;
  logic [4:0] exe_wb_addr;
  logic       mem_wb_wen, mem_wb_data_src, mem_unrec;
  logic [4:0] mem_wb_addr;

  logic [4:0] id_rs, id_rt, id_rd, id_dst;
  logic       rs_used, rt_used, rs_hit, rt_hit;
  logic       hazard, stall_raw, is_jump, load_bubble;
  logic       id_wen, id_mren, id_mwen;

  // ID-stage decode: dest address, source usage, hazard and stall/flush requests.
  always_comb begin
    id_rs = id_inst[25:21];
    id_rt = id_inst[20:16];
    id_rd = id_inst[15:11];
    case (id_wb_addr_src)
      WB_ADDR_RD:   id_dst = id_rd;
      WB_ADDR_RT:   id_dst = id_rt;
      WB_ADDR_LINK: id_dst = 5'(LINK_REG);
      default:      id_dst = id_rd;
    endcase
    // An unrecognized instruction still flows but must not touch any state.
    id_wen  = id_wb_wen  & ~id_unrecognized;
    id_mren = id_mem_ren & ~id_unrecognized;
    id_mwen = id_mem_wen & ~id_unrecognized;

    rs_used = (id_exe_a_src == EXE_A_RS) | (id_pc_src == PC_JR) | (id_pc_src == PC_BRANCH);
    rt_used = (id_exe_b_src == EXE_B_RT) | id_mem_wen;
    // WB is not compared: the register file writes in the first half-cycle.
    rs_hit  = (exe_valid & exe_wb_wen & (exe_wb_addr == id_rs)) |
              (mem_valid & mem_wb_wen & (mem_wb_addr == id_rs));
    rt_hit  = (exe_valid & exe_wb_wen & (exe_wb_addr == id_rt)) |
              (mem_valid & mem_wb_wen & (mem_wb_addr == id_rt));
    hazard  = id_valid & ((rs_used & (id_rs != 5'd0) & rs_hit) |
                          (rt_used & (id_rt != 5'd0) & rt_hit));

    // A taken branch squashes the ID instruction, so its hazard is moot.
    stall_raw   = hazard & ~ex_branch_taken;
    is_jump     = (id_pc_src == PC_JUMP) | (id_pc_src == PC_JR);
    load_bubble = ~id_valid | stall_raw | ex_branch_taken;

    if (en) begin
      if_stall = stall_raw;
      if_flush = ex_branch_taken | (id_valid & ~stall_raw & is_jump);
    end else begin
      if_stall = 1'b0;
      if_flush = 1'b0;
    end
  end

  // ID/EX register: accept the ID bundle or insert a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_valid       <= 1'b0;
      exe_alu_oper    <= 4'd0;
      exe_a_src       <= 2'd0;
      exe_b_src       <= 2'd0;
      exe_is_branch   <= 1'b0;
      exe_mem_ren     <= 1'b0;
      exe_mem_wen     <= 1'b0;
      exe_wb_wen      <= 1'b0;
      exe_wb_data_src <= 1'b0;
      exe_wb_addr     <= 5'd0;
      exe_unrec       <= 1'b0;
    end else if (en) begin
      if (load_bubble) begin
        exe_valid       <= 1'b0;
        exe_alu_oper    <= 4'd0;
        exe_a_src       <= 2'd0;
        exe_b_src       <= 2'd0;
        exe_is_branch   <= 1'b0;
        exe_mem_ren     <= 1'b0;
        exe_mem_wen     <= 1'b0;
        exe_wb_wen      <= 1'b0;
        exe_wb_data_src <= 1'b0;
        exe_wb_addr     <= 5'd0;
        exe_unrec       <= 1'b0;
      end else begin
        exe_valid       <= 1'b1;
        exe_alu_oper    <= id_exe_alu_oper;
        exe_a_src       <= id_exe_a_src;
        exe_b_src       <= id_exe_b_src;
        exe_is_branch   <= (id_pc_src == PC_BRANCH);
        exe_mem_ren     <= id_mren;
        exe_mem_wen     <= id_mwen;
        exe_wb_wen      <= id_wen;
        exe_wb_data_src <= id_wb_data_src;
        exe_wb_addr     <= id_dst;
        exe_unrec       <= id_unrecognized;
      end
    end
  end

  // EX/MEM and MEM/WB registers plus the sticky illegal flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_valid       <= 1'b0;
      mem_ren         <= 1'b0;
      mem_wen         <= 1'b0;
      mem_wb_wen      <= 1'b0;
      mem_wb_data_src <= 1'b0;
      mem_wb_addr     <= 5'd0;
      mem_unrec       <= 1'b0;
      wb_valid        <= 1'b0;
      wb_wen          <= 1'b0;
      wb_data_src     <= 1'b0;
      wb_addr         <= 5'd0;
      illegal_seen    <= 1'b0;
    end else if (en) begin
      mem_valid       <= exe_valid;
      mem_ren         <= exe_mem_ren;
      mem_wen         <= exe_mem_wen;
      mem_wb_wen      <= exe_wb_wen;
      mem_wb_data_src <= exe_wb_data_src;
      mem_wb_addr     <= exe_wb_addr;
      mem_unrec       <= exe_unrec;
      wb_valid        <= mem_valid;
      wb_wen          <= mem_wb_wen;
      wb_data_src     <= mem_wb_data_src;
      wb_addr         <= mem_wb_addr;
      illegal_seen    <= illegal_seen | (mem_valid & mem_unrec);
    end
  end

  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= {CNT_W{1'b0}};
    end else if (en && stall_raw && (stall_count != CNT_MAX)) begin
      stall_count <= stall_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit. A scoreboard queue holds the expected
// contents of each ID/EX load; entries are popped as they reach WB. A second
// instance with a 4-bit counter exercises counter saturation.
module tb_pipe_ctrl_unit;

  localparam logic [2:0] PC_NEXT = 3'd0, PC_JUMP = 3'd1, PC_BRANCH = 3'd3;
  localparam logic [1:0] WB_RD = 2'd0, WB_RT = 2'd1, WB_LINK = 2'd2;

  typedef struct {
    logic v; logic [31:0] inst; logic [2:0] pc; logic [1:0] a; logic [1:0] b;
    logic [3:0] alu; logic mren; logic mwen; logic dsrc; logic wen; logic unrec;
    logic [1:0] wsel; logic [4:0] xaddr; logic xwen;
  } ins_t;

  typedef struct {
    logic v; logic wen; logic dsrc; logic [4:0] addr; logic mren; logic mwen; logic ill;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0, en = 1'b1;
  logic id_valid, id_mem_ren, id_mem_wen, id_wb_data_src, id_wb_wen, id_unrecognized;
  logic [31:0] id_inst;
  logic [2:0] id_pc_src;
  logic [1:0] id_exe_a_src, id_exe_b_src, id_wb_addr_src;
  logic [3:0] id_exe_alu_oper;
  logic ex_branch_taken;
  logic if_stall, if_flush, exe_valid, exe_is_branch, mem_valid, mem_ren, mem_wen;
  logic wb_valid, wb_wen, wb_data_src, illegal_seen;
  logic [3:0] exe_alu_oper;
  logic [1:0] exe_a_src, exe_b_src;
  logic [4:0] wb_addr;
  logic [15:0] stall_count;
  logic s_if_stall, s_if_flush, s_exe_valid, s_exe_is_branch, s_mem_valid, s_mem_ren, s_mem_wen;
  logic s_wb_valid, s_wb_wen, s_wb_data_src, s_illegal_seen;
  logic [3:0] s_exe_alu_oper, s_stall_count;
  logic [1:0] s_exe_a_src, s_exe_b_src;
  logic [4:0] s_wb_addr;

  int errors = 0, checks = 0, exp_cnt = 0;
  logic exp_ill = 1'b0;
  exp_t q[$];
  exp_t last_wb;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.LINK_REG(31), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc_src(id_pc_src), .id_exe_a_src(id_exe_a_src), .id_exe_b_src(id_exe_b_src),
    .id_exe_alu_oper(id_exe_alu_oper), .id_mem_ren(id_mem_ren), .id_mem_wen(id_mem_wen),
    .id_wb_data_src(id_wb_data_src), .id_wb_wen(id_wb_wen), .id_unrecognized(id_unrecognized),
    .id_wb_addr_src(id_wb_addr_src), .ex_branch_taken(ex_branch_taken),
    .if_stall(if_stall), .if_flush(if_flush), .exe_valid(exe_valid), .exe_alu_oper(exe_alu_oper),
    .exe_a_src(exe_a_src), .exe_b_src(exe_b_src), .exe_is_branch(exe_is_branch),
    .mem_valid(mem_valid), .mem_ren(mem_ren), .mem_wen(mem_wen), .wb_valid(wb_valid),
    .wb_wen(wb_wen), .wb_data_src(wb_data_src), .wb_addr(wb_addr),
    .illegal_seen(illegal_seen), .stall_count(stall_count));

  pipe_ctrl_unit #(.LINK_REG(31), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc_src(id_pc_src), .id_exe_a_src(id_exe_a_src), .id_exe_b_src(id_exe_b_src),
    .id_exe_alu_oper(id_exe_alu_oper), .id_mem_ren(id_mem_ren), .id_mem_wen(id_mem_wen),
    .id_wb_data_src(id_wb_data_src), .id_wb_wen(id_wb_wen), .id_unrecognized(id_unrecognized),
    .id_wb_addr_src(id_wb_addr_src), .ex_branch_taken(ex_branch_taken),
    .if_stall(s_if_stall), .if_flush(s_if_flush), .exe_valid(s_exe_valid),
    .exe_alu_oper(s_exe_alu_oper), .exe_a_src(s_exe_a_src), .exe_b_src(s_exe_b_src),
    .exe_is_branch(s_exe_is_branch), .mem_valid(s_mem_valid), .mem_ren(s_mem_ren),
    .mem_wen(s_mem_wen), .wb_valid(s_wb_valid), .wb_wen(s_wb_wen),
    .wb_data_src(s_wb_data_src), .wb_addr(s_wb_addr), .illegal_seen(s_illegal_seen),
    .stall_count(s_stall_count));

  // ---------------- instruction builders ----------------
  function automatic ins_t f_nop();
    ins_t i;
    i = '{v:1'b0, inst:32'd0, pc:PC_NEXT, a:2'd0, b:2'd0, alu:4'd0, mren:1'b0, mwen:1'b0,
          dsrc:1'b0, wen:1'b0, unrec:1'b0, wsel:WB_RD, xaddr:5'd0, xwen:1'b0};
    return i;
  endfunction

  function automatic ins_t f_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    ins_t i = f_nop();
    i.v = 1'b1; i.inst = {6'h00, rs, rt, rd, 5'd0, 6'h20}; i.alu = 4'h2;
    i.wen = 1'b1; i.xaddr = rd; i.xwen = 1'b1;
    return i;
  endfunction

  function automatic ins_t f_lw(input logic [4:0] rs, input logic [4:0] rt);
    ins_t i = f_nop();
    i.v = 1'b1; i.inst = {6'h23, rs, rt, 16'h0004}; i.b = 2'd1; i.alu = 4'h2;
    i.mren = 1'b1; i.dsrc = 1'b1; i.wen = 1'b1; i.wsel = WB_RT; i.xaddr = rt; i.xwen = 1'b1;
    return i;
  endfunction

  function automatic ins_t f_sw(input logic [4:0] rs, input logic [4:0] rt);
    ins_t i = f_nop();
    i.v = 1'b1; i.inst = {6'h2b, rs, rt, 16'h0004}; i.b = 2'd1; i.alu = 4'h2;
    i.mwen = 1'b1; i.wsel = WB_RT; i.xaddr = rt;
    return i;
  endfunction

  function automatic ins_t f_beq(input logic [4:0] rs, input logic [4:0] rt);
    ins_t i = f_nop();
    i.v = 1'b1; i.inst = {6'h04, rs, rt, 16'h0010}; i.pc = PC_BRANCH; i.alu = 4'h6;
    return i;
  endfunction

  function automatic ins_t f_jmp(input logic link);
    ins_t i = f_nop();
    i.v = 1'b1; i.inst = {(link ? 6'h03 : 6'h02), 26'h0000040}; i.pc = PC_JUMP;
    i.a = 2'd1; i.b = 2'd2; i.wen = link; i.xwen = link;
    i.wsel = link ? WB_LINK : WB_RD; i.xaddr = link ? 5'd31 : 5'd0;
    return i;
  endfunction

  function automatic ins_t f_bad(input logic [4:0] rs, input logic [4:0] rd);
    ins_t i = f_nop();
    i.v = 1'b1; i.inst = {6'h3f, rs, 5'd0, rd, 11'd0}; i.unrec = 1'b1;
    i.wen = 1'b1; i.mwen = 1'b1; i.mren = 1'b1; i.xaddr = rd;
    return i;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input ins_t i, input logic br);
    id_valid = i.v; id_inst = i.inst; id_pc_src = i.pc; id_exe_a_src = i.a;
    id_exe_b_src = i.b; id_exe_alu_oper = i.alu; id_mem_ren = i.mren; id_mem_wen = i.mwen;
    id_wb_data_src = i.dsrc; id_wb_wen = i.wen; id_unrecognized = i.unrec;
    id_wb_addr_src = i.wsel; ex_branch_taken = br;
  endtask

  task automatic check_state(input string tag);
    logic [3:0] sat_exp;
    checks++;
    if ({mem_valid, mem_ren, mem_wen} !== {q[0].v, q[0].mren, q[0].mwen}) begin
      errors++;
      $display("FAIL %s mem: got %b%b%b want %b%b%b", tag, mem_valid, mem_ren, mem_wen,
               q[0].v, q[0].mren, q[0].mwen);
    end
    checks++;
    if (exe_valid !== q[1].v) begin
      errors++; $display("FAIL %s exe_valid: got %b want %b", tag, exe_valid, q[1].v);
    end
    checks++;
    if (stall_count !== 16'(exp_cnt)) begin
      errors++; $display("FAIL %s stall_count: got %0d want %0d", tag, stall_count, exp_cnt);
    end
    sat_exp = (exp_cnt > 15) ? 4'hF : 4'(exp_cnt);
    checks++;
    if (s_stall_count !== sat_exp) begin
      errors++; $display("FAIL %s sat_count: got %0d want %0d", tag, s_stall_count, sat_exp);
    end
    checks++;
    if (illegal_seen !== exp_ill) begin
      errors++; $display("FAIL %s illegal_seen: got %b want %b", tag, illegal_seen, exp_ill);
    end
  endtask

  // One enabled cycle: check stall/flush mid-cycle, then the scoreboard after the edge.
  task automatic step(input ins_t i, input logic br, input logic xst, input logic xfl,
                      input string tag);
    exp_t e;
    exp_t got;
    en = 1'b1;
    drive(i, br);
    @(negedge clk);
    checks++;
    if ({if_stall, if_flush} !== {xst, xfl}) begin
      errors++;
      $display("FAIL %s stall/flush: got %b/%b want %b/%b", tag, if_stall, if_flush, xst, xfl);
    end
    @(posedge clk); #1;
    if (xst) exp_cnt++;
    if (!i.v || xst || br) begin
      e = '{v:1'b0, wen:1'b0, dsrc:1'b0, addr:5'd0, mren:1'b0, mwen:1'b0, ill:1'b0};
    end else begin
      e = '{v:1'b1, wen:i.xwen, dsrc:i.dsrc, addr:i.xaddr, mren:i.mren & ~i.unrec,
            mwen:i.mwen & ~i.unrec, ill:i.unrec};
    end
    q.push_back(e);
    got = q.pop_front();
    last_wb = got;
    if (got.ill) exp_ill = 1'b1;
    checks++;
    if ({wb_valid, wb_wen, wb_data_src, wb_addr} !== {got.v, got.wen, got.dsrc, got.addr}) begin
      errors++;
      $display("FAIL %s wb: got v%b w%b d%b a%0d want v%b w%b d%b a%0d", tag, wb_valid,
               wb_wen, wb_data_src, wb_addr, got.v, got.wen, got.dsrc, got.addr);
    end
    check_state(tag);
  endtask

  // One cycle with en=0: nothing may move and fetch control must be quiet.
  task automatic freeze(input ins_t i, input logic br);
    en = 1'b0;
    drive(i, br);
    @(negedge clk);
    checks++;
    if ({if_stall, if_flush} !== 2'b00) begin
      errors++; $display("FAIL freeze stall/flush: got %b/%b want 0/0", if_stall, if_flush);
    end
    @(posedge clk); #1;
    checks++;
    if ({wb_valid, wb_wen, wb_data_src, wb_addr} !==
        {last_wb.v, last_wb.wen, last_wb.dsrc, last_wb.addr}) begin
      errors++;
      $display("FAIL freeze wb: got v%b a%0d want v%b a%0d", wb_valid, wb_addr, last_wb.v,
               last_wb.addr);
    end
    check_state("freeze");
    en = 1'b1;
  endtask

  task automatic do_reset();
    exp_t z;
    z = '{v:1'b0, wen:1'b0, dsrc:1'b0, addr:5'd0, mren:1'b0, mwen:1'b0, ill:1'b0};
    rst = 1'b0; en = 1'b1;
    drive(f_nop(), 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    q.push_back(z); q.push_back(z);
    last_wb = z; exp_cnt = 0; exp_ill = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) step(f_nop(), 1'b0, 1'b0, 1'b0, "drain");
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [37:0] snap;
    do_reset();
    check_state("reset");
    step(f_r(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, 1'b0, "pre_add");
    step(f_r(5'd3, 5'd2, 5'd4), 1'b0, 1'b1, 1'b0, "pre_sub");
    #2 rst = 1'b0;
    #1;
    snap = {exe_valid, exe_alu_oper, exe_a_src, exe_b_src, exe_is_branch, mem_valid, mem_ren,
            mem_wen, wb_valid, wb_wen, wb_data_src, wb_addr, illegal_seen, stall_count};
    checks++;
    if (snap !== 38'd0 || if_stall !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %h stall %b want 0", snap, if_stall);
    end
    do_reset();
  endtask

  task automatic test_stall();
    step(f_r(5'd1, 5'd2, 5'd3), 1'b0, 1'b0, 1'b0, "add_r3");
    checks++;
    if (exe_alu_oper !== 4'h2) begin
      errors++; $display("FAIL exe_alu_oper: got %h want 2", exe_alu_oper);
    end
    step(f_r(5'd3, 5'd2, 5'd3), 1'b0, 1'b1, 1'b0, "sub_st1");
    step(f_r(5'd3, 5'd2, 5'd3), 1'b0, 1'b1, 1'b0, "sub_st2");
    step(f_r(5'd3, 5'd2, 5'd3), 1'b0, 1'b0, 1'b0, "sub_go");
    drain();
    checks++;
    if (stall_count !== 16'd2) begin
      errors++; $display("FAIL stall_count_two: got %0d want 2", stall_count);
    end
  endtask

  task automatic test_r0_and_store();
    step(f_r(5'd1, 5'd2, 5'd0), 1'b0, 1'b0, 1'b0, "wr_r0");
    step(f_r(5'd0, 5'd0, 5'd6), 1'b0, 1'b0, 1'b0, "rd_r0");
    step(f_lw(5'd1, 5'd5), 1'b0, 1'b0, 1'b0, "lw_r5");
    step(f_sw(5'd1, 5'd5), 1'b0, 1'b1, 1'b0, "sw_st1");
    step(f_sw(5'd1, 5'd5), 1'b0, 1'b1, 1'b0, "sw_st2");
    step(f_sw(5'd1, 5'd5), 1'b0, 1'b0, 1'b0, "sw_go");
    drain();
  endtask

  task automatic test_branch();
    step(f_r(5'd1, 5'd2, 5'd7), 1'b0, 1'b0, 1'b0, "add_r7");
    step(f_beq(5'd1, 5'd2), 1'b0, 1'b0, 1'b0, "beq");
    checks++;
    if (exe_is_branch !== 1'b1) begin
      errors++; $display("FAIL exe_is_branch: got %b want 1", exe_is_branch);
    end
    step(f_r(5'd7, 5'd2, 5'd12), 1'b1, 1'b0, 1'b1, "br_taken");
    drain();
  endtask

  task automatic test_jump();
    step(f_jmp(1'b1), 1'b0, 1'b0, 1'b1, "jal");
    step(f_jmp(1'b0), 1'b0, 1'b0, 1'b1, "j");
    drain();
  endtask

  task automatic test_illegal();
    step(f_bad(5'd1, 5'd13), 1'b0, 1'b0, 1'b0, "bad");
    drain();
    drain();
    checks++;
    if (illegal_seen !== 1'b1) begin
      errors++; $display("FAIL illegal_sticky: got %b want 1", illegal_seen);
    end
  endtask

  task automatic test_freeze();
    step(f_r(5'd1, 5'd2, 5'd10), 1'b0, 1'b0, 1'b0, "add_r10");
    step(f_lw(5'd1, 5'd11), 1'b0, 1'b0, 1'b0, "lw_r11");
    for (int k = 0; k < 5; k++) freeze(f_r(5'd10, 5'd2, 5'd14), 1'b0);
    step(f_r(5'd10, 5'd2, 5'd14), 1'b0, 1'b1, 1'b0, "thaw_st");
    step(f_r(5'd10, 5'd2, 5'd14), 1'b0, 1'b0, 1'b0, "thaw_go");
    drain();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 10; k++) begin
      step(f_r(5'd9, 5'd9, 5'd9), 1'b0, 1'b0, 1'b0, "sat_go");
      step(f_r(5'd9, 5'd9, 5'd9), 1'b0, 1'b1, 1'b0, "sat_st1");
      step(f_r(5'd9, 5'd9, 5'd9), 1'b0, 1'b1, 1'b0, "sat_st2");
    end
    drain();
    checks++;
    if (s_stall_count !== 4'hF) begin
      errors++; $display("FAIL sat_final: got %h want f", s_stall_count);
    end
  endtask

  initial begin
    drive(f_nop(), 1'b0);
    test_reset();
    test_stall();
    test_r0_and_store();
    test_branch();
    test_jump();
    test_illegal();
    test_freeze();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
